// File: rtl/nexys_starship_rng_pkg.sv
// Shared constants, lane control bundle and the lane seed function
// used by the Nexys Starship random event generator.
package nexys_starship_rng_pkg;

  localparam logic [15:0] DEFAULT_POLY       = 16'hB400;
  localparam logic [15:0] DEFAULT_RESET_SEED = 16'hACE1;
  localparam logic [15:0] LANE_SEED_STRIDE   = 16'h9E37;
  localparam logic [31:0] LOCKUP_STATE       = 32'd1;

  typedef struct packed {
    logic step;
    logic reseed;
  } lane_ctrl_t;

  // Each lane gets a distinct seed; a zero result would lock the LFSR, so it is forced to 1.
  function automatic logic [31:0] lane_seed(input logic [31:0]  base,
                                            input int unsigned  lane,
                                            input int unsigned  width);
    logic [31:0] mask;
    logic [31:0] mixed;
    mask  = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    mixed = (base ^ (lane * 32'(LANE_SEED_STRIDE))) & mask;
    if (mixed == 32'd0) begin
      mixed = LOCKUP_STATE;
    end
    return mixed;
  endfunction

endpackage

// File: rtl/nexys_starship_rng_lane.sv
// One event lane: Galois LFSR, threshold compare, sticky flag with
// acknowledge, and a post-acknowledge cooldown counter.
module nexys_starship_rng_lane
  import nexys_starship_rng_pkg::*;
#(
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] POLY       = LFSR_W'(DEFAULT_POLY),
  parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_W'(DEFAULT_RESET_SEED),
  parameter int unsigned       LANE_IDX   = 0,
  parameter int unsigned       THRESH_W   = 8,
  parameter int unsigned       COOLDOWN   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  lane_ctrl_t          ctrl,
  input  logic [LFSR_W-1:0]   seed_base,
  input  logic [THRESH_W-1:0] thresh,
  input  logic                ack,
  output logic                flag,
  output logic [LFSR_W-1:0]   state
);

  localparam int unsigned       CD_W        = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0]   CD_LOAD     = CD_W'(COOLDOWN);
  localparam logic [LFSR_W-1:0] RESET_STATE = LFSR_W'(lane_seed(32'(RESET_SEED), LANE_IDX, LFSR_W));

  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic                flag_q, flag_d;
  logic [CD_W-1:0]     cd_q, cd_d;
  logic [THRESH_W-1:0] sample;
  logic [LFSR_W-1:0]   shifted;
  logic                hit;

  // The sample comes from the pre-step state, so a hit reflects the value seen this cycle.
  always_comb begin
    sample  = lfsr_q[THRESH_W-1:0];
    shifted = lfsr_q >> 1;
    hit     = ctrl.step & (sample < thresh) & ~flag_q & (cd_q == '0);
    lfsr_d  = lfsr_q;
    flag_d  = flag_q;
    cd_d    = cd_q;
    if (ctrl.reseed) begin
      lfsr_d = LFSR_W'(lane_seed(32'(seed_base), LANE_IDX, LFSR_W));
      flag_d = 1'b0;
      cd_d   = '0;
    end else begin
      if (ctrl.step) begin
        if (lfsr_q == '0) begin
          lfsr_d = LFSR_W'(LOCKUP_STATE);
        end else if (lfsr_q[0]) begin
          lfsr_d = shifted ^ POLY;
        end else begin
          lfsr_d = shifted;
        end
        if (cd_q != '0) begin
          cd_d = cd_q - CD_W'(1);
        end
      end
      if (ack && flag_q) begin
        flag_d = 1'b0;
        cd_d   = CD_LOAD;
      end else if (hit) begin
        flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_STATE;
      flag_q <= 1'b0;
      cd_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      flag_q <= flag_d;
      cd_q   <= cd_d;
    end
  end

  assign flag  = flag_q;
  assign state = lfsr_q;

endmodule

// File: rtl/nexys_starship_rng_bank.sv
// Multi-lane pseudo-random event bank for Nexys Starship: NUM_CH
// independent event lanes plus a request/valid random hex port.
module nexys_starship_rng_bank
  import nexys_starship_rng_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 8,
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] POLY       = LFSR_W'(DEFAULT_POLY),
  parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_W'(DEFAULT_RESET_SEED),
  parameter int unsigned       THRESH_W   = 8,
  parameter int unsigned       COOLDOWN   = 4,
  parameter int unsigned       HEX_W      = 4
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         En,
  input  logic                         Seed_load,
  input  logic [LFSR_W-1:0]            Seed,
  input  logic [NUM_CH*THRESH_W-1:0]   Thresh,
  input  logic [NUM_CH-1:0]            Ack,
  output logic [NUM_CH-1:0]            Flag,
  input  logic                         Hex_req,
  output logic [HEX_W-1:0]             Hex_out,
  output logic                         Hex_valid
);

  lane_ctrl_t                ctrl;
  logic [NUM_CH*LFSR_W-1:0]  lane_state;
  logic                      lane_state_unused;
  logic [HEX_W-1:0]          hex_out_q, hex_out_d;
  logic                      hex_valid_q, hex_valid_d;

  always_comb begin
    ctrl.step   = En & ~Seed_load;
    ctrl.reseed = Seed_load;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    nexys_starship_rng_lane #(
      .LFSR_W     (LFSR_W),
      .POLY       (POLY),
      .RESET_SEED (RESET_SEED),
      .LANE_IDX   (i),
      .THRESH_W   (THRESH_W),
      .COOLDOWN   (COOLDOWN)
    ) u_lane (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .ctrl      (ctrl),
      .seed_base (Seed),
      .thresh    (Thresh[i*THRESH_W +: THRESH_W]),
      .ack       (Ack[i]),
      .flag      (Flag[i]),
      .state     (lane_state[i*LFSR_W +: LFSR_W])
    );
  end

  // Only the top nibble of lane 0 feeds the hex port; the other lane states stay internal.
  assign lane_state_unused = ^lane_state;

  always_comb begin
    hex_out_d   = hex_out_q;
    hex_valid_d = 1'b0;
    if (Hex_req && !Seed_load) begin
      hex_out_d   = lane_state[LFSR_W-1 -: HEX_W];
      hex_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hex_out_q   <= '0;
      hex_valid_q <= 1'b0;
    end else begin
      hex_out_q   <= hex_out_d;
      hex_valid_q <= hex_valid_d;
    end
  end

  assign Hex_out   = hex_out_q;
  assign Hex_valid = hex_valid_q;

endmodule

// File: tb/tb_nexys_starship_rng_bank.sv
// Directed self-checking bench for nexys_starship_rng_bank with default
// parameters (8 lanes, 16-bit LFSR, 8-bit thresholds, cooldown 4).
module tb_nexys_starship_rng_bank;

  logic        Clk;
  logic        Reset_n;
  logic        En;
  logic        Seed_load;
  logic [15:0] Seed;
  logic [63:0] Thresh;
  logic [7:0]  Ack;
  logic [7:0]  Flag;
  logic        Hex_req;
  logic [3:0]  Hex_out;
  logic        Hex_valid;

  int total = 0;
  int bad   = 0;

  nexys_starship_rng_bank dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .En        (En),
    .Seed_load (Seed_load),
    .Seed      (Seed),
    .Thresh    (Thresh),
    .Ack       (Ack),
    .Flag      (Flag),
    .Hex_req   (Hex_req),
    .Hex_out   (Hex_out),
    .Hex_valid (Hex_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] model_step(input logic [15:0] s);
    if (s == 16'h0000) return 16'h0001;
    return s[0] ? ({1'b0, s[15:1]} ^ 16'hB400) : {1'b0, s[15:1]};
  endfunction

  function automatic logic [15:0] model_seed(input logic [15:0] b, input int i);
    logic [31:0] k;
    logic [15:0] v;
    k = i * 32'h0000_9E37;
    v = b ^ k[15:0];
    if (v == 16'h0000) v = 16'h0001;
    return v;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_seed(input logic [15:0] s);
    Seed_load = 1'b1;
    Seed      = s;
    tick();
    Seed_load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (Flag !== 8'h00) begin bad++; $display("[TB] FAIL reset_flag: got %h want %h", Flag, 8'h00); end
    total++; if (Hex_out !== 4'h0) begin bad++; $display("[TB] FAIL reset_hex: got %h want %h", Hex_out, 4'h0); end
    total++; if (Hex_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", Hex_valid); end
    tick();
    total++; if (dut.g_lane[0].u_lane.lfsr_q !== 16'hACE1) begin bad++; $display("[TB] FAIL reset_lfsr0: got %h want ACE1", dut.g_lane[0].u_lane.lfsr_q); end
    total++; if (dut.g_lane[1].u_lane.lfsr_q !== 16'h32D6) begin bad++; $display("[TB] FAIL reset_lfsr1: got %h want 32D6", dut.g_lane[1].u_lane.lfsr_q); end
    Reset_n = 1'b1;
    tick();
    total++; if (dut.g_lane[0].u_lane.lfsr_q !== 16'hACE1) begin bad++; $display("[TB] FAIL reset_hold_lfsr0: got %h want ACE1", dut.g_lane[0].u_lane.lfsr_q); end
  endtask

  task automatic test_seed_walk();
    logic [15:0] want [3];
    want[0] = 16'hB400; want[1] = 16'h5A00; want[2] = 16'h2D00;
    Thresh = '0;
    do_seed(16'h0001);
    total++; if (dut.g_lane[0].u_lane.lfsr_q !== 16'h0001) begin bad++; $display("[TB] FAIL seed_lfsr0: got %h want 0001", dut.g_lane[0].u_lane.lfsr_q); end
    total++; if (dut.g_lane[1].u_lane.lfsr_q !== 16'h9E36) begin bad++; $display("[TB] FAIL seed_lfsr1: got %h want 9E36", dut.g_lane[1].u_lane.lfsr_q); end
    En = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (dut.g_lane[0].u_lane.lfsr_q !== want[k]) begin bad++; $display("[TB] FAIL walk_lfsr0_%0d: got %h want %h", k, dut.g_lane[0].u_lane.lfsr_q, want[k]); end
      if (k == 0) begin
        total++; if (dut.g_lane[1].u_lane.lfsr_q !== 16'h4F1B) begin bad++; $display("[TB] FAIL walk_lfsr1: got %h want 4F1B", dut.g_lane[1].u_lane.lfsr_q); end
      end
    end
    En = 1'b0;
  endtask

  task automatic test_zero_seed_hold();
    logic [7:0] seen;
    seen = 8'h00;
    do_seed(16'h0000);
    total++; if (dut.g_lane[0].u_lane.lfsr_q !== 16'h0001) begin bad++; $display("[TB] FAIL zero_seed_lfsr0: got %h want 0001", dut.g_lane[0].u_lane.lfsr_q); end
    total++; if (dut.g_lane[1].u_lane.lfsr_q !== 16'h9E37) begin bad++; $display("[TB] FAIL zero_seed_lfsr1: got %h want 9E37", dut.g_lane[1].u_lane.lfsr_q); end
    total++; if (dut.g_lane[2].u_lane.lfsr_q !== 16'h3C6E) begin bad++; $display("[TB] FAIL zero_seed_lfsr2: got %h want 3C6E", dut.g_lane[2].u_lane.lfsr_q); end
    Thresh = '1;
    En     = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      seen |= Flag;
    end
    total++; if (seen !== 8'h00) begin bad++; $display("[TB] FAIL hold_flags: got %h want 00", seen); end
    total++; if (dut.g_lane[0].u_lane.lfsr_q !== 16'h0001) begin bad++; $display("[TB] FAIL hold_lfsr0: got %h want 0001", dut.g_lane[0].u_lane.lfsr_q); end
    total++; if (dut.g_lane[1].u_lane.lfsr_q !== 16'h9E37) begin bad++; $display("[TB] FAIL hold_lfsr1: got %h want 9E37", dut.g_lane[1].u_lane.lfsr_q); end
    Thresh = '0;
  endtask

  task automatic test_hit_sticky();
    Thresh = 64'h0000_0000_0000_0002;
    do_seed(16'h0001);
    total++; if (Flag !== 8'h00) begin bad++; $display("[TB] FAIL hit_pre: got %h want 00", Flag); end
    En = 1'b1;
    tick();
    total++; if (Flag !== 8'h01) begin bad++; $display("[TB] FAIL hit_latency: got %h want 01", Flag); end
    tick(); tick(); tick();
    total++; if (Flag !== 8'h01) begin bad++; $display("[TB] FAIL hit_sticky: got %h want 01", Flag); end
    En = 1'b0;
  endtask

  task automatic test_thresh_boundary();
    Thresh = '1;
    do_seed(16'h12FF);
    total++; if (dut.g_lane[0].u_lane.lfsr_q !== 16'h12FF) begin bad++; $display("[TB] FAIL bound_seed: got %h want 12FF", dut.g_lane[0].u_lane.lfsr_q); end
    En = 1'b1;
    tick();
    En = 1'b0;
    total++; if (Flag !== 8'hFE) begin bad++; $display("[TB] FAIL bound_ff: got %h want FE", Flag); end
    Thresh = '0;
  endtask

  task automatic test_cooldown_ack();
    Thresh = 64'h0000_0000_0000_00FF;
    do_seed(16'h0001);
    En = 1'b1;
    tick();
    total++; if (Flag !== 8'h01) begin bad++; $display("[TB] FAIL cd_set: got %h want 01", Flag); end
    Ack = 8'h01;
    tick();
    Ack = 8'h00;
    total++; if (Flag !== 8'h00) begin bad++; $display("[TB] FAIL cd_ack_clear: got %h want 00", Flag); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (Flag !== 8'h00) begin bad++; $display("[TB] FAIL cd_block_%0d: got %h want 00", k, Flag); end
    end
    tick();
    total++; if (Flag !== 8'h01) begin bad++; $display("[TB] FAIL cd_refire: got %h want 01", Flag); end
    En = 1'b0;
    Thresh = '0;
  endtask

  task automatic test_ack_ignored();
    Thresh = '0;
    do_seed(16'h0001);
    En  = 1'b1;
    Ack = 8'h02;
    tick();
    Ack = 8'h00;
    total++; if (Flag !== 8'h00) begin bad++; $display("[TB] FAIL ack_idle: got %h want 00", Flag); end
    Thresh = 64'h0000_0000_0000_FF00;
    tick();
    total++; if (Flag !== 8'h02) begin bad++; $display("[TB] FAIL ack_no_cd: got %h want 02", Flag); end
    En = 1'b0;
    Thresh = '0;
  endtask

  task automatic test_thresh_zero_soak();
    logic [7:0] seen;
    seen = 8'h00;
    Thresh = '0;
    do_seed(16'h0001);
    En = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      tick();
      seen |= Flag;
    end
    En = 1'b0;
    total++; if (seen !== 8'h00) begin bad++; $display("[TB] FAIL zero_soak: got %h want 00", seen); end
  endtask

  task automatic test_refire_soak();
    logic [15:0] m [8];
    logic [7:0]  ef, ef_n, prev_obs;
    int          ecd [8];
    int          mism, rises_obs, rises_exp;
    mism = 0; rises_obs = 0; rises_exp = 0;
    Thresh = '1;
    do_seed(16'h0001);
    for (int i = 0; i < 8; i++) begin
      m[i]   = model_seed(16'h0001, i);
      ecd[i] = 0;
    end
    ef = 8'h00;
    prev_obs = 8'h00;
    En = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      Ack  = ef;
      ef_n = ef;
      for (int i = 0; i < 8; i++) begin
        if (ef[i]) begin
          ef_n[i] = 1'b0;
          ecd[i]  = 4;
        end else begin
          if (m[i][7:0] != 8'hFF && ecd[i] == 0) ef_n[i] = 1'b1;
          if (ecd[i] > 0) ecd[i] = ecd[i] - 1;
        end
        m[i] = model_step(m[i]);
      end
      rises_exp += $countones(ef_n & ~ef);
      ef = ef_n;
      tick();
      rises_obs += $countones(Flag & ~prev_obs);
      prev_obs = Flag;
      if (Flag !== ef) mism++;
    end
    Ack = 8'h00;
    En  = 1'b0;
    total++; if (mism !== 0) begin bad++; $display("[TB] FAIL refire_flags: got %0d mismatched cycles want 0", mism); end
    total++; if (rises_obs !== rises_exp) begin bad++; $display("[TB] FAIL refire_count: got %0d want %0d", rises_obs, rises_exp); end
    Thresh = '0;
  endtask

  task automatic test_hex();
    Thresh = '0;
    do_seed(16'h0001);
    Hex_req = 1'b1;
    tick();
    Hex_req = 1'b0;
    total++; if (Hex_valid !== 1'b1) begin bad++; $display("[TB] FAIL hex_valid1: got %b want 1", Hex_valid); end
    total++; if (Hex_out !== 4'h0) begin bad++; $display("[TB] FAIL hex_out1: got %h want 0", Hex_out); end
    tick();
    total++; if (Hex_valid !== 1'b0) begin bad++; $display("[TB] FAIL hex_pulse: got %b want 0", Hex_valid); end
    En = 1'b1;
    tick();
    Hex_req = 1'b1;
    tick();
    total++; if (Hex_out !== 4'hB || Hex_valid !== 1'b1) begin bad++; $display("[TB] FAIL hex_b2b_a: got %h/%b want B/1", Hex_out, Hex_valid); end
    tick();
    total++; if (Hex_out !== 4'h5 || Hex_valid !== 1'b1) begin bad++; $display("[TB] FAIL hex_b2b_b: got %h/%b want 5/1", Hex_out, Hex_valid); end
    Hex_req = 1'b0;
    En      = 1'b0;
    tick();
    total++; if (Hex_out !== 4'h5 || Hex_valid !== 1'b0) begin bad++; $display("[TB] FAIL hex_hold: got %h/%b want 5/0", Hex_out, Hex_valid); end
    Hex_req   = 1'b1;
    Seed_load = 1'b1;
    Seed      = 16'h0001;
    tick();
    Hex_req   = 1'b0;
    Seed_load = 1'b0;
    total++; if (Hex_out !== 4'h5 || Hex_valid !== 1'b0) begin bad++; $display("[TB] FAIL hex_drop: got %h/%b want 5/0", Hex_out, Hex_valid); end
  endtask

  task automatic test_async_reset();
    Thresh = '1;
    do_seed(16'h0001);
    En = 1'b1;
    tick();
    Ack     = 8'h01;
    Hex_req = 1'b1;
    tick();
    Ack     = 8'h00;
    Hex_req = 1'b0;
    En      = 1'b0;
    total++; if (Flag !== 8'hFE || Hex_out !== 4'hB || Hex_valid !== 1'b1) begin bad++; $display("[TB] FAIL prereset: got %h/%h/%b want FE/B/1", Flag, Hex_out, Hex_valid); end
    total++; if (dut.g_lane[0].u_lane.cd_q !== 3'd4) begin bad++; $display("[TB] FAIL prereset_cd: got %0d want 4", dut.g_lane[0].u_lane.cd_q); end
    #2;
    Reset_n = 1'b0;
    #1;
    total++; if (Flag !== 8'h00 || Hex_out !== 4'h0 || Hex_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_outputs: got %h/%h/%b want 00/0/0", Flag, Hex_out, Hex_valid); end
    total++; if (dut.g_lane[0].u_lane.cd_q !== 3'd0) begin bad++; $display("[TB] FAIL async_cd: got %0d want 0", dut.g_lane[0].u_lane.cd_q); end
    total++; if (dut.g_lane[1].u_lane.lfsr_q !== 16'h32D6) begin bad++; $display("[TB] FAIL async_lfsr1: got %h want 32D6", dut.g_lane[1].u_lane.lfsr_q); end
    #2;
    Reset_n = 1'b1;
    Thresh  = '0;
    tick();
    total++; if (Flag !== 8'h00 || Hex_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset: got %h/%b want 00/0", Flag, Hex_valid); end
  endtask

  initial begin
    Reset_n   = 1'b0;
    En        = 1'b0;
    Seed_load = 1'b0;
    Seed      = 16'h0000;
    Thresh    = '0;
    Ack       = 8'h00;
    Hex_req   = 1'b0;
    test_reset();
    test_seed_walk();
    test_zero_seed_hold();
    test_hit_sticky();
    test_thresh_boundary();
    test_cooldown_ack();
    test_ack_ignored();
    test_thresh_zero_soak();
    test_refire_soak();
    test_hex();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
